// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the sequential multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MULDIV_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t o);
        unique case (o)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic op_a_signed(input muldiv_op_t o);
        unique case (o)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t o);
        unique case (o)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiplier / restoring divider on unsigned magnitudes,
// with sign fix-up. One 2*DATA_WIDTH accumulator and one adder are shared.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH,
    parameter int unsigned ITER       = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned AW = DATA_WIDTH + 2;
    localparam int unsigned CW = $clog2(ITER + 1);

    muldiv_state_t  state_q, state_d;
    muldiv_op_t     op_q, op_in;
    logic [2*W-1:0] acc_q, acc_step;
    logic [W-1:0]   opnd_q, result_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_a_q, dz_q, skip_q;

    logic           accept;
    logic           a_neg, b_neg, in_div, in_dz, in_ovf;
    logic [W-1:0]   a_mag, b_mag, acc_hi, acc_lo;
    logic [AW-1:0]  add_x, add_y, add_sum;
    logic           add_inv, add_cin;
    logic [W-1:0]   fix_sel, fix_val;
    logic           fix_neg, fix_hi;

    assign accept = (state_q == IDLE) && start && !flush;
    assign acc_hi = acc_q[2*W-1:W];
    assign acc_lo = acc_q[W-1:0];

    // Operand decode at request time: magnitudes and the divide short-cuts.
    always_comb begin
        op_in  = muldiv_op_t'(op);
        a_neg  = op_a_signed(op_in) & src_a[W-1];
        b_neg  = op_b_signed(op_in) & src_b[W-1];
        a_mag  = a_neg ? -src_a : src_a;
        b_mag  = b_neg ? -src_b : src_b;
        in_div = op_is_div(op_in);
        in_dz  = in_div && (src_b == '0);
        in_ovf = in_div && op_b_signed(op_in) && (src_a == {1'b1, {(W-1){1'b0}}})
                 && (src_b == '1);
    end

    // Output selection in FIX: which half/quotient/remainder and whether to negate.
    always_comb begin
        fix_sel = '0;
        fix_neg = 1'b0;
        fix_hi  = 1'b0;
        unique case (op_q)
            OP_MUL: begin
                fix_sel = acc_lo;
                fix_neg = neg_q;
            end
            OP_MULH, OP_MULHSU, OP_MULHU: begin
                fix_sel = acc_hi;
                fix_neg = neg_q;
                fix_hi  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                fix_sel = dz_q ? '1 : acc_lo;
                fix_neg = neg_q & ~dz_q;
            end
            OP_REM, OP_REMU: begin
                // Divide by zero leaves the dividend magnitude in the low half.
                fix_sel = dz_q ? acc_lo : acc_hi;
                fix_neg = neg_a_q;
            end
            default: ;
        endcase
    end

    // Shared adder operand steering: multiply add, divide trial subtract, FIX negate.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_inv = 1'b0;
        add_cin = 1'b0;
        if (state_q == FIX) begin
            if (fix_hi) begin
                // High half of -P is ~hi plus the carry out of negating lo.
                add_x   = {2'b00, ~fix_sel};
                add_cin = (acc_lo == '0);
            end else begin
                add_y   = {2'b00, fix_sel};
                add_inv = 1'b1;
                add_cin = 1'b1;
            end
        end else if (state_q == CALC) begin
            if (op_is_div(op_q)) begin
                add_x   = {1'b0, acc_q[2*W-1:W-1]};
                add_y   = {2'b00, opnd_q};
                add_inv = 1'b1;
                add_cin = 1'b1;
            end else begin
                add_x = {2'b00, acc_hi};
                add_y = {2'b00, opnd_q};
            end
        end
    end

    assign add_sum = add_x + (add_inv ? ~add_y : add_y) + AW'(add_cin);

    // One radix-2 iteration of the accumulator, and the sign-corrected result.
    always_comb begin
        if (op_is_div(op_q)) begin
            acc_step = add_sum[W+1] ? {acc_q[2*W-2:0], 1'b0}
                                    : {add_sum[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            acc_step = acc_q[0] ? {add_sum[W:0], acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        end
        fix_val = fix_neg ? add_sum[W-1:0] : fix_sel;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (skip_q || (cnt_q == CW'(ITER - 1))) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        cnt_d = (state_q == CALC && state_d == CALC) ? cnt_q + 1'b1 : '0;
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == CALC) || (state_q == FIX);
        done = (state_q == DONE);
    end

    // Datapath registers: latch on accept, iterate in CALC, publish in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            dz_q     <= 1'b0;
            skip_q   <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                opnd_q  <= in_div ? b_mag : a_mag;
                acc_q   <= in_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                neg_q   <= a_neg ^ b_neg;
                neg_a_q <= a_neg;
                dz_q    <= in_dz;
                skip_q  <= in_dz | in_ovf;
            end else if (state_q == CALC && !skip_q && !flush) begin
                acc_q <= acc_step;
            end
            if (state_q == FIX && !flush) begin
                result_q <= fix_val;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results/done cycles queued at issue,
// compared when done pulses.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op_r;
    logic [31:0] a_r, b_r;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t scb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_id  = 0;

    muldiv_seq #(.DATA_WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op_r),
        .src_a (a_r),
        .src_b (b_r),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      la, lb;
        int          ia, ib;
        logic [63:0] p;
        logic        ovf;
        la  = longint'($signed(a));
        lb  = longint'($signed(b));
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = la * lb; return p[63:32]; end
            3'd2: begin p = la * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b);
        if (o >= 3'd4 && b == 0) return 3;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Raise start for one cycle; optionally record the expected outcome.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit push);
        exp_t e;
        if (push) begin
            e.id  = n_id;
            e.res = exp;
            e.cyc = cyc + lat;
            scb.push_back(e);
            n_id++;
        end
        op_r  = o;
        a_r   = a;
        b_r   = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (scb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (scb.size() != 0) begin
            check_eq("drain_timeout", scb.size(), 0);
            scb.delete();
        end
        step();
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        issue(o, a, b, exp, lat_of(o, a, b), 1'b1);
        drain(60);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (scb.size() == 0) begin
                check_eq("done_unexpected", {63'b0, done}, 64'd0);
            end else begin
                mon_e = scb.pop_front();
                check_eq($sformatf("result_%0d", mon_e.id), result, mon_e.res);
                check_eq($sformatf("latency_%0d", mon_e.id), cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          c;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op_r  = 3'd0;
        a_r   = '0;
        b_r   = '0;
        #3;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_result", result, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // MUL 7 * -3 with busy window.
        c = cyc;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        check_eq("mul_busy_first", busy, 1);
        while (cyc < c + 33) step();
        check_eq("mul_busy_last", busy, 1);
        check_eq("mul_not_done_early", done, 0);
        step();
        check_eq("mul_busy_at_done", busy, 0);
        drain(10);

        // Directed results.
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(3'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run(3'd7, 32'd100, 32'd7, 32'd2);
        run(3'd5, 32'd100, 32'd7, 32'd14);

        // Flush mid-DIVU: no done, result held, restart right after.
        c = cyc;
        issue(3'd5, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        while (cyc < c + 10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_busy", busy, 0);
        check_eq("flush_result_held", result, 32'd14);
        issue(3'd0, 32'd6, 32'd9, 32'd54, 34, 1'b1);
        check_eq("restart_busy", busy, 1);
        drain(60);

        // Flush and start together: flush wins.
        op_r  = 3'd0;
        a_r   = 32'd3;
        b_r   = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        check_eq("flush_start_busy", busy, 0);
        step();

        // Start pulses while busy are ignored.
        issue(3'd0, 32'd5, 32'd6, 32'd30, 34, 1'b1);
        op_r  = 3'd4;
        a_r   = 32'd100;
        b_r   = 32'd3;
        start = 1'b1;
        repeat (5) step();
        start = 1'b0;
        drain(60);

        // Start during DONE is not accepted.
        c = cyc;
        issue(3'd0, 32'd3, 32'd4, 32'd12, 34, 1'b1);
        while (cyc < c + 34) step();
        check_eq("done_cycle_done", done, 1);
        op_r  = 3'd0;
        a_r   = 32'd9;
        b_r   = 32'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_in_done_busy", busy, 0);
        step();
        check_eq("start_in_done_idle", busy, 0);

        // Reset mid-operation, then start on the first edge after release.
        c = cyc;
        issue(3'd0, 32'd5, 32'd5, 32'd0, 0, 1'b0);
        while (cyc < c + 8) step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_result", result, 0);
        check_eq("rst_mid_done", done, 0);
        step();
        rst_n = 1'b1;
        issue(3'd7, 32'd50, 32'd8, 32'd2, 34, 1'b1);
        check_eq("post_rst_busy", busy, 1);
        drain(60);

        // Random sweep with boundary-heavy operands.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run(ro, ra, rb, model(ro, ra, rb));
        end

        check_eq("scoreboard_empty", scb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ITER, default 32 (= DATA_WIDTH), number of compute iterations.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request strobe; valid only while busy=0.
REQ-006 op  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 src_a  in  DATA_WIDTH  rs1 value (multiplicand/dividend).
REQ-008 src_b  in  DATA_WIDTH  rs2 value (multiplier/divisor).
REQ-009 flush  in  1  pipeline flush; aborts operation in flight.
REQ-010 busy  out  1  high from the cycle after start is accepted until done; drives pipeline stall.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 result  out  DATA_WIDTH  registered result; holds until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-014 IDLE: start=1 and flush=0 at edge N -> latch op/operands, go CALC, busy=1 from N+1.
REQ-015 start while busy=1 SHALL be ignored; operands and op SHALL NOT be re-latched.
REQ-016 CALC: one radix-2 step per cycle on unsigned magnitudes (shift-add multiply, restoring divide); iteration counter counts 0..ITER-1, then go FIX.
REQ-017 FIX: apply sign correction and select output half/quotient/remainder; go DONE.
REQ-018 DONE: done=1, result updated, busy=0 in the same cycle; next state IDLE. Normal latency: start at N -> done at N+ITER+2 (N+34 for default).
REQ-019 Signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU both unsigned.
REQ-020 Product SHALL be computed at 2*DATA_WIDTH; MUL returns low half, MULH* return high half.
REQ-021 Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-022 Divide by zero (DIV/DIVU/REM/REMU, b=0): skip CALC, go FIX directly; quotient = all ones, remainder = a; done at N+3.
REQ-023 Signed overflow (DIV/REM, a=-2^(DATA_WIDTH-1), b=-1): skip CALC; quotient = a, remainder = 0; done at N+3.
REQ-024 flush=1 in any state SHALL return to IDLE next edge, busy=0, no done pulse, result unchanged.
REQ-025 flush and start in the same cycle: flush wins; request SHALL NOT be accepted.
REQ-026 start in the cycle done=1 SHALL NOT be accepted (FSM is leaving DONE); accepted from IDLE only.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
REQ-028 Reset mid-operation SHALL discard the operation with no done pulse after release.
REQ-029 Deassertion SHALL take effect at the first clk edge with rst_n high; start is acceptable at that edge.

Structure
REQ-030 Package muldiv_pkg SHALL hold the op enum (muldiv_op_t), the state enum (muldiv_state_t), and DATA_WIDTH default constant.
REQ-031 Decode in the main pipeline controller SHALL use muldiv_pkg op values; no duplicated literals.
REQ-032 Single module; no sub-module required. Multiply and divide SHALL share one 2*DATA_WIDTH accumulator and one DATA_WIDTH adder/subtractor.

Verification
REQ-033 MUL a=7, b=-3, start at N -> done at N+34, result=0xFFFFFFEB; busy high N+1..N+33.
REQ-034 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-035 DIV a=-7, b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=0x80000000, b=0 -> 0xFFFFFFFF at N+3; REM a=0x80000000, b=-1 -> 0 at N+3.
REQ-036 Start DIVU at N, flush at N+10 -> busy=0 at N+11, no done, result keeps previous value; new start at N+11 accepted.
REQ-037 Second start pulses at N+1..N+5 during MUL -> ignored, result matches first operands; rst_n low at N+8 -> busy=0, result=0 immediately, no done afterward.
